// File: rtl/sd_emmc_io_reg.sv
// SD/eMMC pad register bank: registered drive/tristate per line, a configurable input
// capture chain, turnaround blanking of the captured value, and falling-edge pulses.
module sd_emmc_io_reg #(
  parameter int    DATA_WIDTH   = 1,
  parameter string PLACE_IN_IOB = "FALSE",
  parameter int    IN_STAGES    = 2,
  parameter int    TURN_CYCLES  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] out_d,
  input  logic [DATA_WIDTH-1:0] out_oe,
  output logic [DATA_WIDTH-1:0] pad_o,
  output logic [DATA_WIDTH-1:0] pad_t,
  input  logic [DATA_WIDTH-1:0] pad_i,
  output logic [DATA_WIDTH-1:0] in_q,
  output logic [DATA_WIDTH-1:0] in_fall
);

  localparam int BLANK = TURN_CYCLES + IN_STAGES;
  localparam int CW    = $clog2(BLANK + 1);

  logic [DATA_WIDTH-1:0]         stage1;
  logic [DATA_WIDTH-1:0]         lastStage;
  logic [DATA_WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]         blanked;
  logic [DATA_WIDTH-1:0]         prev_q;
  logic [DATA_WIDTH-1:0]         inFall_q, inFall_d;

  // Pad-facing flops stay a single register each with nothing between them and the pad,
  // so the IOB attribute can pack them into the IO tile.
  generate
    if (PLACE_IN_IOB == "TRUE") begin : g_iob
      (* IOB = "TRUE" *) logic [DATA_WIDTH-1:0] padO_q;
      (* IOB = "TRUE" *) logic [DATA_WIDTH-1:0] padT_q;
      (* IOB = "TRUE" *) logic [DATA_WIDTH-1:0] stage1_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          padO_q   <= '1;
          padT_q   <= '1;
          stage1_q <= '1;
        end else begin
          padO_q   <= out_d;
          padT_q   <= ~out_oe;
          stage1_q <= pad_i;
        end
      end

      assign pad_o  = padO_q;
      assign pad_t  = padT_q;
      assign stage1 = stage1_q;
    end else begin : g_fabric
      (* IOB = "FALSE" *) logic [DATA_WIDTH-1:0] padO_q;
      (* IOB = "FALSE" *) logic [DATA_WIDTH-1:0] padT_q;
      (* IOB = "FALSE" *) logic [DATA_WIDTH-1:0] stage1_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          padO_q   <= '1;
          padT_q   <= '1;
          stage1_q <= '1;
        end else begin
          padO_q   <= out_d;
          padT_q   <= ~out_oe;
          stage1_q <= pad_i;
        end
      end

      assign pad_o  = padO_q;
      assign pad_t  = padT_q;
      assign stage1 = stage1_q;
    end
  endgenerate

  generate
    if (IN_STAGES == 1) begin : g_chain_none
      assign lastStage = stage1;
    end else begin : g_chain
      logic [IN_STAGES-2:0][DATA_WIDTH-1:0] chain_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          chain_q <= '1;
        end else begin
          chain_q[0] <= stage1;
          for (int k = 1; k < IN_STAGES - 1; k++) begin
            chain_q[k] <= chain_q[k-1];
          end
        end
      end

      assign lastStage = chain_q[IN_STAGES-2];
    end
  endgenerate

  // A driven line keeps its counter loaded, so blanking runs on seamlessly through release.
  always_comb begin
    cnt_d   = cnt_q;
    blanked = '0;
    for (int n = 0; n < DATA_WIDTH; n++) begin
      if (!pad_t[n]) begin
        cnt_d[n] = CW'(BLANK);
      end else if (cnt_q[n] != '0) begin
        cnt_d[n] = cnt_q[n] - CW'(1);
      end
      blanked[n] = (cnt_q[n] != '0);
    end
  end

  assign in_q     = lastStage | blanked;
  assign inFall_d = prev_q & ~in_q;
  assign in_fall  = inFall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      prev_q   <= '1;
      inFall_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      prev_q   <= in_q;
      inFall_q <= inFall_d;
    end
  end

endmodule

// File: tb/tb_sd_emmc_io_reg.sv
// Directed bench for sd_emmc_io_reg with four lines, two input stages and two turnaround
// cycles (blank window of four cycles).
module tb_sd_emmc_io_reg;

  logic       clk;
  logic       rst;
  logic [3:0] outD;
  logic [3:0] outOe;
  logic [3:0] padO;
  logic [3:0] padT;
  logic [3:0] padI;
  logic [3:0] inQ;
  logic [3:0] inFall;

  int checks = 0;
  int passed = 0;

  sd_emmc_io_reg #(
    .DATA_WIDTH  (4),
    .PLACE_IN_IOB("FALSE"),
    .IN_STAGES   (2),
    .TURN_CYCLES (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .out_d  (outD),
    .out_oe (outOe),
    .pad_o  (padO),
    .pad_t  (padT),
    .pad_i  (padI),
    .in_q   (inQ),
    .in_fall(inFall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every tick leaves the bench 1 ns after a rising edge, where outputs are stable
  // and new inputs can be set up for the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] oe, input logic [3:0] d, input logic [3:0] pi);
    outOe = oe;
    outD  = d;
    padI  = pi;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(4'b0000, 4'b1111, 4'b1111);
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(4'b1111, 4'b0000, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({padT, padO, inQ, inFall} !== {4'b1111, 4'b1111, 4'b1111, 4'b0000})
        $display("[TB] FAIL reset_hold cyc%0d: got t=%b o=%b q=%b f=%b, want t=1111 o=1111 q=1111 f=0000",
                 i, padT, padO, inQ, inFall);
      else passed++;
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({inQ, inFall} !== {4'b1111, 4'b0000})
      $display("[TB] FAIL reset_after: got q=%b f=%b, want q=1111 f=0000", inQ, inFall);
    else passed++;
  endtask

  task automatic test_output_latency();
    doReset();
    applyStimulus(4'b1111, 4'b1010, 4'b1111);
    checks++;
    if (padT !== 4'b1111)
      $display("[TB] FAIL out_before_edge: got t=%b, want 1111", padT);
    else passed++;
    tick();
    checks++;
    if ({padT, padO} !== {4'b0000, 4'b1010})
      $display("[TB] FAIL out_drive: got t=%b o=%b, want t=0000 o=1010", padT, padO);
    else passed++;
    applyStimulus(4'b0000, 4'b0101, 4'b1111);
    tick();
    checks++;
    if ({padT, padO} !== {4'b1111, 4'b0101})
      $display("[TB] FAIL out_release: got t=%b o=%b, want t=1111 o=0101", padT, padO);
    else passed++;
    applyStimulus(4'b0110, 4'b0011, 4'b1111);
    tick();
    checks++;
    if ({padT, padO} !== {4'b1001, 4'b0011})
      $display("[TB] FAIL out_mixed: got t=%b o=%b, want t=1001 o=0011", padT, padO);
    else passed++;
    applyStimulus(4'b0000, 4'b1111, 4'b1111);
    tick();
  endtask

  task automatic test_input_edge();
    doReset();
    applyStimulus(4'b0000, 4'b1111, 4'b1110);
    tick();
    checks++;
    if ({inQ, inFall} !== {4'b1111, 4'b0000})
      $display("[TB] FAIL in_E: got q=%b f=%b, want q=1111 f=0000", inQ, inFall);
    else passed++;
    tick();
    checks++;
    if ({inQ, inFall} !== {4'b1110, 4'b0000})
      $display("[TB] FAIL in_E1: got q=%b f=%b, want q=1110 f=0000", inQ, inFall);
    else passed++;
    applyStimulus(4'b0000, 4'b1111, 4'b1010);
    tick();
    checks++;
    if ({inQ, inFall} !== {4'b1110, 4'b0001})
      $display("[TB] FAIL in_E2: got q=%b f=%b, want q=1110 f=0001", inQ, inFall);
    else passed++;
    tick();
    checks++;
    if ({inQ, inFall} !== {4'b1010, 4'b0000})
      $display("[TB] FAIL in_E3: got q=%b f=%b, want q=1010 f=0000", inQ, inFall);
    else passed++;
    tick();
    checks++;
    if ({inQ, inFall} !== {4'b1010, 4'b0100})
      $display("[TB] FAIL in_line2_fall: got q=%b f=%b, want q=1010 f=0100", inQ, inFall);
    else passed++;
    tick();
    checks++;
    if (inFall !== 4'b0000)
      $display("[TB] FAIL in_fall_single: got f=%b, want 0000", inFall);
    else passed++;
  endtask

  task automatic test_blanking();
    doReset();
    applyStimulus(4'b0001, 4'b0000, 4'b1110);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({inQ, inFall} !== {4'b1111, 4'b0000})
        $display("[TB] FAIL blank_drive cyc%0d: got q=%b f=%b, want q=1111 f=0000", i, inQ, inFall);
      else passed++;
    end
    applyStimulus(4'b0000, 4'b0000, 4'b1110);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({inQ, inFall} !== {4'b1111, 4'b0000})
        $display("[TB] FAIL blank_window B+%0d: got q=%b f=%b, want q=1111 f=0000", i, inQ, inFall);
      else passed++;
    end
    tick();
    checks++;
    if ({inQ, inFall} !== {4'b1110, 4'b0000})
      $display("[TB] FAIL blank_end B+4: got q=%b f=%b, want q=1110 f=0000", inQ, inFall);
    else passed++;
    tick();
    checks++;
    if (inFall !== 4'b0001)
      $display("[TB] FAIL blank_fall B+5: got f=%b, want 0001", inFall);
    else passed++;
    tick();
    checks++;
    if (inFall !== 4'b0000)
      $display("[TB] FAIL blank_fall_clear B+6: got f=%b, want 0000", inFall);
    else passed++;
  endtask

  task automatic test_redrive();
    doReset();
    applyStimulus(4'b0001, 4'b0000, 4'b1110);
    for (int i = 0; i < 5; i++) tick();
    applyStimulus(4'b0000, 4'b0000, 4'b1110);
    tick();
    tick();
    applyStimulus(4'b0001, 4'b0000, 4'b1110);
    tick();
    applyStimulus(4'b0000, 4'b0000, 4'b1110);
    for (int i = 2; i <= 6; i++) begin
      checks++;
      if ({inQ, inFall} !== {4'b1111, 4'b0000})
        $display("[TB] FAIL redrive_hold B+%0d: got q=%b f=%b, want q=1111 f=0000", i, inQ, inFall);
      else passed++;
      tick();
    end
    checks++;
    if ({inQ, inFall} !== {4'b1110, 4'b0000})
      $display("[TB] FAIL redrive_end B+7: got q=%b f=%b, want q=1110 f=0000", inQ, inFall);
    else passed++;
    tick();
    checks++;
    if (inFall !== 4'b0001)
      $display("[TB] FAIL redrive_fall B+8: got f=%b, want 0001", inFall);
    else passed++;
  endtask

  task automatic test_reset_mid_blank();
    doReset();
    applyStimulus(4'b0001, 4'b0000, 4'b1110);
    for (int i = 0; i < 5; i++) tick();
    applyStimulus(4'b0000, 4'b0000, 4'b1110);
    tick();
    rst = 1'b1;
    applyStimulus(4'b1111, 4'b0000, 4'b1110);
    tick();
    checks++;
    if ({padT, inQ, inFall} !== {4'b1111, 4'b1111, 4'b0000})
      $display("[TB] FAIL midreset_edge: got t=%b q=%b f=%b, want t=1111 q=1111 f=0000", padT, inQ, inFall);
    else passed++;
    rst = 1'b0;
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (inFall !== ((i == 3) ? 4'b1111 : 4'b0000))
        $display("[TB] FAIL midreset_fall R+%0d: got f=%b, want %b", i, inFall,
                 (i == 3) ? 4'b1111 : 4'b0000);
      else passed++;
    end
    checks++;
    if (inQ !== 4'b0000)
      $display("[TB] FAIL midreset_inq: got q=%b, want 0000", inQ);
    else passed++;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(4'b0000, 4'b1111, 4'b1111);
    test_reset();
    test_output_latency();
    test_input_edge();
    test_blanking();
    test_redrive();
    test_reset_mid_blank();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
